// File: rtl/bbot_rc_pkg.sv
// Shared types and setpoint scaling for the RC pulse bank.
package bbot_rc_pkg;

    localparam int RC_PCT_MAX = 100;
    localparam int RC_PCT_MIN = -100;

    typedef logic signed [31:0] rc_width_t;

    // Clamp a signed percent byte to +/-100 and scale it around the neutral width.
    function automatic rc_width_t pct_to_width(input logic [7:0] pct,
                                               input int zero_clks,
                                               input int range_mult);
        int sp;
        sp = int'($signed(pct));
        if (sp > RC_PCT_MAX)
            sp = RC_PCT_MAX;
        else if (sp < RC_PCT_MIN)
            sp = RC_PCT_MIN;
        return rc_width_t'(zero_clks + sp * range_mult);
    endfunction

endpackage

// File: rtl/bbot_rc_channel.sv
// One RC output: target/shadow width, optional slew (BBOT_RC_SLEW_LIMIT_EN),
// RC input synchroniser and output source mux.
module bbot_rc_channel #(
    parameter int ZERO_CLKS  = 75000,
    parameter int RANGE_MULT = 250
`ifdef BBOT_RC_SLEW_LIMIT_EN
    ,
    parameter int SLEW_STEP  = 500
`endif
) (
    input  logic        clock,
    input  logic        reset_l,
    input  logic        wr,
    input  logic [7:0]  data,
    input  logic        failsafe,
    input  logic        frame_zero,
    input  logic [31:0] frame_cnt,
    input  logic        src_sel,
    input  logic        rc_in,
    output logic        ppm_out
);
    import bbot_rc_pkg::*;

    rc_width_t target;
    rc_width_t active;
    rc_width_t eff_target;
    rc_width_t next_active;
    rc_width_t width_now;
    logic      rc_s1;
    logic      rc_s2;
    logic      gen;
`ifdef BBOT_RC_SLEW_LIMIT_EN
    rc_width_t delta;
`endif

    always_ff @(posedge clock) begin
        if (!reset_l)
            target <= rc_width_t'(ZERO_CLKS);
        else if (wr)
            target <= pct_to_width(data, ZERO_CLKS, RANGE_MULT);
        else if (failsafe)
            target <= rc_width_t'(ZERO_CLKS);
    end

    always_comb begin
        eff_target = failsafe ? rc_width_t'(ZERO_CLKS) : target;
`ifdef BBOT_RC_SLEW_LIMIT_EN
        delta = eff_target - active;
        if (delta > rc_width_t'(SLEW_STEP))
            next_active = active + rc_width_t'(SLEW_STEP);
        else if (delta < -rc_width_t'(SLEW_STEP))
            next_active = active - rc_width_t'(SLEW_STEP);
        else
            next_active = eff_target;
`else
        next_active = eff_target;
`endif
        // The boundary cycle already compares against the width being loaded.
        width_now = frame_zero ? next_active : active;
        gen       = rc_width_t'(frame_cnt) < width_now;
    end

    always_ff @(posedge clock) begin
        if (!reset_l)
            active <= rc_width_t'(ZERO_CLKS);
        else if (frame_zero)
            active <= next_active;
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            rc_s1   <= 1'b0;
            rc_s2   <= 1'b0;
            ppm_out <= 1'b0;
        end else begin
            rc_s1   <= rc_in;
            rc_s2   <= rc_s1;
            ppm_out <= src_sel ? gen : rc_s2;
        end
    end

endmodule

// File: rtl/bbot_rc_pwm_bank.sv
// RC servo/ESC pulse bank: shared frame timer, setpoint decode and watchdog.
// Optional per-frame slew limiting under BBOT_RC_SLEW_LIMIT_EN.
module bbot_rc_pwm_bank #(
    parameter int NUM_CH      = 4,
    parameter int PERIOD_CLKS = 1100000,
    parameter int ZERO_CLKS   = 75000,
    parameter int RANGE_MULT  = 250,
    parameter int WDOG_CLKS   = 25000000,
    parameter int SLEW_STEP   = 500
) (
    input  logic              clock,
    input  logic              reset_l,
    input  logic              setpt_valid,
    input  logic [2:0]        setpt_ch,
    input  logic [7:0]        setpt_data,
    input  logic [NUM_CH-1:0] src_sel,
    input  logic [NUM_CH-1:0] rc_in,
    output logic [NUM_CH-1:0] ppm_out,
    output logic              frame_start,
    output logic              failsafe
);
    import bbot_rc_pkg::*;

    rc_width_t   frame_cnt;
    logic        frame_zero;
    logic        wr_ok;
    logic [31:0] wdog;

    if (NUM_CH < 1 || NUM_CH > 8 || SLEW_STEP < 0) begin : g_bad_cfg
        $error("bbot_rc_pwm_bank: unsupported NUM_CH or SLEW_STEP");
    end

    always_comb begin
        frame_zero = (frame_cnt == '0);
        wr_ok      = setpt_valid && (int'(setpt_ch) < NUM_CH);
        failsafe   = (wdog == '0);
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_zero;
            frame_cnt   <= (frame_cnt == rc_width_t'(PERIOD_CLKS - 1)) ? '0 : frame_cnt + 1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_l)
            wdog <= 32'(WDOG_CLKS);
        else if (wr_ok)
            wdog <= 32'(WDOG_CLKS);
        else if (wdog != '0)
            wdog <= wdog - 32'd1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;

        always_comb wr = wr_ok && (setpt_ch == 3'(i));

        bbot_rc_channel #(
            .ZERO_CLKS (ZERO_CLKS),
            .RANGE_MULT(RANGE_MULT)
`ifdef BBOT_RC_SLEW_LIMIT_EN
            ,
            .SLEW_STEP (SLEW_STEP)
`endif
        ) u_ch (
            .clock     (clock),
            .reset_l   (reset_l),
            .wr        (wr),
            .data      (setpt_data),
            .failsafe  (failsafe),
            .frame_zero(frame_zero),
            .frame_cnt (frame_cnt),
            .src_sel   (src_sel[i]),
            .rc_in     (rc_in[i]),
            .ppm_out   (ppm_out[i])
        );
    end

endmodule

// File: tb/tb_bbot_rc_pwm_bank.sv
// Randomised bench for bbot_rc_pwm_bank with a frame-level reference model.
module tb_bbot_rc_pwm_bank;

    localparam int NCH = 4;
    localparam int P   = 1200;
    localparam int Z   = 600;
    localparam int M   = 5;
    localparam int WD  = 12000;
    localparam int S   = 50;

    logic           clock = 1'b0;
    logic           reset_l = 1'b0;
    logic           setpt_valid = 1'b0;
    logic [2:0]     setpt_ch = '0;
    logic [7:0]     setpt_data = '0;
    logic [NCH-1:0] src_sel = '1;
    logic [NCH-1:0] rc_in = '0;
    logic [NCH-1:0] ppm_out;
    logic           frame_start;
    logic           failsafe;

    int checks = 0;
    int errors = 0;

    // Model state: per-channel target/active widths, frame index since reset,
    // edge number of the last accepted write, and a write not yet folded in.
    int         model_tgt[NCH];
    int         model_act[NCH];
    int         frame_no;
    int         last_wr_edge;
    bit         pend_v;
    int         pend_e;
    logic [2:0] pend_ch;
    logic [7:0] pend_d;

    int meas_w[NCH];
    bit meas_ok;
    bit prev_fs;
    int rise_frame, rise_idx, fall_frame, fall_idx;

    bbot_rc_pwm_bank #(
        .NUM_CH(NCH), .PERIOD_CLKS(P), .ZERO_CLKS(Z),
        .RANGE_MULT(M), .WDOG_CLKS(WD), .SLEW_STEP(S)
    ) dut (
        .clock(clock), .reset_l(reset_l), .setpt_valid(setpt_valid),
        .setpt_ch(setpt_ch), .setpt_data(setpt_data), .src_sel(src_sel),
        .rc_in(rc_in), .ppm_out(ppm_out), .frame_start(frame_start),
        .failsafe(failsafe)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic int pct_w(logic [7:0] d);
        int s;
        s = int'($signed(d));
        if (s > 100) s = 100;
        if (s < -100) s = -100;
        return Z + s * M;
    endfunction

    function automatic int toward(int a, int t);
`ifdef BBOT_RC_SLEW_LIMIT_EN
        if (t > a + S) return a + S;
        if (t < a - S) return a - S;
        return t;
`else
        return (a == t) ? a : t;
`endif
    endfunction

    // Watchdog expired during the cycle that ends at clock edge e.
    function automatic bit fs_at(int e);
        return (e - 1 - last_wr_edge) >= WD;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            model_tgt[c] = Z;
            model_act[c] = Z;
        end
        frame_no = 0;
        last_wr_edge = 0;
        pend_v = 0;
        prev_fs = 0;
    endtask

    task automatic model_apply_write(int e, logic [2:0] ch, logic [7:0] d);
        if (int'(ch) < NCH) begin
            if (fs_at(e))
                for (int c = 0; c < NCH; c++) model_tgt[c] = Z;
            model_tgt[int'(ch)] = pct_w(d);
            last_wr_edge = e;
        end
    endtask

    task automatic model_frame();
        int b;
        bit fs;
        b = 1 + frame_no * P;
        if (pend_v && pend_e < b) begin
            model_apply_write(pend_e, pend_ch, pend_d);
            pend_v = 0;
        end
        fs = fs_at(b);
        for (int c = 0; c < NCH; c++)
            model_act[c] = toward(model_act[c], fs ? Z : model_tgt[c]);
        if (pend_v) begin
            model_apply_write(pend_e, pend_ch, pend_d);
            pend_v = 0;
        end
    endtask

    // Observe one frame from its frame_start sample; optionally issue one write
    // whose strobe is driven at sample wr_at.
    task automatic measure_frame(int wr_at, logic [2:0] ch, logic [7:0] d);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * P) begin
            @(negedge clock);
            n++;
        end
        meas_ok = (n == 0) && (frame_start === 1'b1);
        for (int c = 0; c < NCH; c++) meas_w[c] = 0;
        for (int i = 0; i < P; i++) begin
            for (int c = 0; c < NCH; c++)
                if (ppm_out[c] === 1'b1) meas_w[c]++;
            if (i > 0 && frame_start !== 1'b0) meas_ok = 0;
            if (failsafe === 1'b1 && !prev_fs && rise_frame < 0) begin
                rise_frame = frame_no;
                rise_idx = i;
            end
            if (failsafe === 1'b0 && prev_fs && fall_frame < 0) begin
                fall_frame = frame_no;
                fall_idx = i;
            end
            prev_fs = (failsafe === 1'b1);
            if (i == wr_at) begin
                setpt_valid = 1'b1;
                setpt_ch = ch;
                setpt_data = d;
            end else begin
                setpt_valid = 1'b0;
            end
            @(negedge clock);
        end
        setpt_valid = 1'b0;
        frame_no++;
    endtask

    task automatic do_frame(int at, logic [2:0] ch, logic [7:0] d);
        int e;
        model_frame();
        e = 2 + frame_no * P + at;
        measure_frame(at, ch, d);
        if (at >= 0) begin
            pend_v = 1;
            pend_e = e;
            pend_ch = ch;
            pend_d = d;
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        src_sel = '1;
        rc_in = '0;
        repeat (5) @(negedge clock);
        checks++;
        if (ppm_out !== '0) begin errors++; $display("FAIL reset_ppm: got %b expected 0", ppm_out); end
        checks++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        checks++;
        if (failsafe !== 1'b0) begin errors++; $display("FAIL reset_failsafe: got %b expected 0", failsafe); end
        reset_l = 1'b1;
        model_reset();
        rise_frame = -1;
        fall_frame = -1;
        @(negedge clock);
        for (int f = 0; f < 2; f++) begin
            do_frame(-1, 3'd0, 8'd0);
            checks++;
            if (!meas_ok) begin errors++; $display("FAIL reset_frame_timing: frame %0d got bad frame_start spacing expected %0d", frame_no - 1, P); end
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (meas_w[c] !== model_act[c]) begin
                    errors++;
                    $display("FAIL reset_width ch%0d: got %0d expected %0d", c, meas_w[c], model_act[c]);
                end
            end
        end
    endtask

    task automatic test_midframe();
        logic [2:0] ch;
        logic [7:0] d;
        int at;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin ch = 3'd1; d = 8'd100; end
            else if (k == 1) begin ch = 3'd1; d = 8'h80; end
            else begin ch = 3'($urandom_range(0, NCH - 1)); d = 8'($urandom); end
            at = $urandom_range(1, P - 3);
            for (int f = 0; f < 2; f++) begin
                if (f == 0) do_frame(at, ch, d);
                else do_frame(-1, 3'd0, 8'd0);
                checks++;
                if (!meas_ok) begin errors++; $display("FAIL midframe_timing: frame %0d bad frame_start spacing", frame_no - 1); end
                for (int c = 0; c < NCH; c++) begin
                    checks++;
                    if (meas_w[c] !== model_act[c]) begin
                        errors++;
                        $display("FAIL midframe_width iter %0d frame %0d ch%0d: got %0d expected %0d",
                                 k, f, c, meas_w[c], model_act[c]);
                    end
                end
            end
        end
    endtask

    task automatic test_frame_zero_write();
        for (int f = 0; f < 3; f++) begin
            if (f == 0) do_frame(P - 1, 3'd2, 8'd40);
            else do_frame(-1, 3'd0, 8'd0);
            checks++;
            if (!meas_ok) begin errors++; $display("FAIL zero_write_timing: frame %0d bad frame_start spacing", f); end
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (meas_w[c] !== model_act[c]) begin
                    errors++;
                    $display("FAIL zero_write_width frame %0d ch%0d: got %0d expected %0d", f, c, meas_w[c], model_act[c]);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        int e0, fexp, iexp, fw;
        do_frame(100, 3'd0, 8'd50);
        e0 = 2 + (frame_no - 1) * P + 100;
        do_frame(300, 3'd7, 8'($urandom));
        fexp = (e0 + WD - 1) / P;
        iexp = (e0 + WD - 1) % P;
        rise_frame = -1;
        fall_frame = -1;
        while (frame_no <= fexp + 1) begin
            do_frame(-1, 3'd0, 8'd0);
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (meas_w[c] !== model_act[c]) begin
                    errors++;
                    $display("FAIL wdog_width frame %0d ch%0d: got %0d expected %0d", frame_no - 1, c, meas_w[c], model_act[c]);
                end
            end
        end
        checks++;
        if (rise_frame !== fexp || rise_idx !== iexp) begin
            errors++;
            $display("FAIL wdog_expire: got frame %0d sample %0d expected frame %0d sample %0d",
                     rise_frame, rise_idx, fexp, iexp);
        end
        fw = frame_no;
        do_frame(200, 3'd0, 8'd50);
        checks++;
        if (fall_frame !== fw || fall_idx !== 201) begin
            errors++;
            $display("FAIL wdog_clear: got frame %0d sample %0d expected frame %0d sample 201", fall_frame, fall_idx, fw);
        end
        for (int f = 0; f < 2; f++) begin
            do_frame(-1, 3'd0, 8'd0);
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (meas_w[c] !== model_act[c]) begin
                    errors++;
                    $display("FAIL wdog_resume frame %0d ch%0d: got %0d expected %0d", f, c, meas_w[c], model_act[c]);
                end
            end
        end
    endtask

    task automatic test_passthrough();
        logic d0, d1, d2, level;
        int remaining;
        src_sel[3] = 1'b0;
        rc_in[3] = 1'b0;
        repeat (4) @(negedge clock);
        d0 = 0; d1 = 0; d2 = 0; level = 0; remaining = 8;
        for (int t = 0; t < 600; t++) begin
            checks++;
            if (ppm_out[3] !== d2) begin
                errors++;
                $display("FAIL passthrough t=%0d: got %b expected %b", t, ppm_out[3], d2);
            end
            if (remaining == 0) begin
                level = ~level;
                remaining = level ? $urandom_range(20, 80) : $urandom_range(5, 40);
            end
            remaining--;
            rc_in[3] = level;
            rc_in[2:0] = 3'($urandom);
            d2 = d1; d1 = d0; d0 = level;
            @(negedge clock);
        end
    endtask

    task automatic test_src_switch();
        int n;
        src_sel[3] = 1'b0;
        rc_in = '0;
        rc_in[3] = 1'b1;
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * P) begin @(negedge clock); n++; end
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL switch_sync: got no frame_start within %0d cycles", 2 * P); end
        repeat (P - 20) @(negedge clock);
        checks++;
        if (ppm_out[3] !== 1'b1) begin errors++; $display("FAIL switch_rc_high: got %b expected 1", ppm_out[3]); end
        src_sel[3] = 1'b1;
        @(negedge clock);
        checks++;
        if (ppm_out[3] !== 1'b0) begin errors++; $display("FAIL switch_to_gen_low: got %b expected 0", ppm_out[3]); end
        src_sel[3] = 1'b0;
        @(negedge clock);
        checks++;
        if (ppm_out[3] !== 1'b1) begin errors++; $display("FAIL switch_to_rc_high: got %b expected 1", ppm_out[3]); end
        rc_in[3] = 1'b0;
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * P) begin @(negedge clock); n++; end
        checks++;
        if (ppm_out[3] !== 1'b0) begin errors++; $display("FAIL switch_rc_low: got %b expected 0", ppm_out[3]); end
        src_sel[3] = 1'b1;
        @(negedge clock);
        checks++;
        if (ppm_out[3] !== 1'b1) begin errors++; $display("FAIL switch_to_gen_high: got %b expected 1", ppm_out[3]); end
    endtask

    task automatic test_reset_midframe();
        int n;
        src_sel = '1;
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * P) begin @(negedge clock); n++; end
        repeat (50) @(negedge clock);
        checks++;
        if (ppm_out !== '1) begin errors++; $display("FAIL midreset_before: got %b expected 1111", ppm_out); end
        reset_l = 1'b0;
        @(negedge clock);
        checks++;
        if (ppm_out !== '0 || frame_start !== 1'b0 || failsafe !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got ppm %b fs %b failsafe %b expected all 0", ppm_out, frame_start, failsafe);
        end
        repeat (3) @(negedge clock);
        reset_l = 1'b1;
        model_reset();
        @(negedge clock);
        do_frame(-1, 3'd0, 8'd0);
        checks++;
        if (!meas_ok) begin errors++; $display("FAIL midreset_restart: frame did not restart at release"); end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (meas_w[c] !== model_act[c]) begin
                errors++;
                $display("FAIL midreset_width ch%0d: got %0d expected %0d", c, meas_w[c], model_act[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_midframe();
        test_frame_zero_write();
        test_watchdog();
        test_passthrough();
        test_src_switch();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
